// File: rtl/hatch_pkg.sv
// Shared types and constants for the hatching-stage controller.
package hatch_pkg;

  // Width of the stage code sent to the display.
  localparam int unsigned STAGE_W = 4;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StIncubate = 3'd1,
    StCold     = 3'd2,
    StHatched  = 3'd3,
    StDead     = 3'd4
  } state_e;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hatch_stage_ctrl_if.sv
// Key/temperature inputs and display-side outputs of the stage controller.
interface hatch_stage_ctrl_if;
  import hatch_pkg::*;

  logic               start;
  logic               temp;
  logic [STAGE_W-1:0] num;
  logic               stage_adv;
  logic               cold;
  logic               hatched;
  logic               dead;
  logic               busy;

  modport master (
    output start, temp,
    input  num, stage_adv, cold, hatched, dead, busy
  );

  modport slave (
    input  start, temp,
    output num, stage_adv, cold, hatched, dead, busy
  );

endinterface

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-cycle-per-second tick.
module sec_prescaler
  import hatch_pkg::*;
#(
  parameter int unsigned CLK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = cnt_w(CLK_HZ);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count 0..CLK_HZ-1 while enabled; clear has priority.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == CntLast);

endmodule

// File: rtl/hatch_stage_ctrl.sv
// Incubation FSM: advances the stage code each STAGE_SEC warm seconds,
// freezes it while cold and kills the egg after COLD_LIMIT cold seconds.
module hatch_stage_ctrl
  import hatch_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 1000,
  parameter int unsigned STAGE_SEC  = 2,
  parameter int unsigned NUM_STAGES = 12,
  parameter int unsigned COLD_LIMIT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  hatch_stage_ctrl_if.slave  bus
);

  localparam int unsigned SecW  = cnt_w(STAGE_SEC);
  localparam int unsigned ColdW = cnt_w(COLD_LIMIT);
  localparam logic [SecW-1:0]    SecLast  = SecW'(STAGE_SEC - 1);
  localparam logic [ColdW-1:0]   ColdLast = ColdW'(COLD_LIMIT - 1);
  localparam logic [STAGE_W-1:0] NumLast  = STAGE_W'(NUM_STAGES - 1);

  state_e             state_q, state_d;
  logic [STAGE_W-1:0] num_q, num_d, num_inc;
  logic [SecW-1:0]    stage_sec_q, stage_sec_d;
  logic [ColdW-1:0]   cold_sec_q, cold_sec_d;
  logic               stage_adv_q, stage_adv_d;
  logic               cold_q, hatched_q, dead_q, busy_q;
  logic               run, sec_tick;

  // Prescaler only runs while incubating or cold; otherwise it is held at 0.
  assign run = (state_q == StIncubate) || (state_q == StCold);

  sec_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (!run),
    .en_i   (run),
    .tick_o (sec_tick)
  );

  assign num_inc = num_q + 1'b1;

  // Next-state and counter update; temp changes take priority over a tick.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    stage_sec_d = stage_sec_q;
    cold_sec_d  = cold_sec_q;
    stage_adv_d = 1'b0;
    unique case (state_q)
      StIdle, StHatched, StDead: begin
        if (bus.start) begin
          state_d     = StIncubate;
          num_d       = '0;
          stage_sec_d = '0;
          cold_sec_d  = '0;
        end
      end
      StIncubate: begin
        if (!bus.temp) begin
          state_d    = StCold;
          cold_sec_d = '0;
        end else if (sec_tick) begin
          if (stage_sec_q == SecLast) begin
            stage_sec_d = '0;
            num_d       = num_inc;
            stage_adv_d = 1'b1;
            if (num_inc == NumLast) begin
              state_d = StHatched;
            end
          end else begin
            stage_sec_d = stage_sec_q + 1'b1;
          end
        end
      end
      StCold: begin
        if (bus.temp) begin
          state_d = StIncubate;
        end else if (sec_tick) begin
          if (cold_sec_q == ColdLast) begin
            state_d = StDead;
          end else begin
            cold_sec_d = cold_sec_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and flags decoded from the next state, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      num_q       <= '0;
      stage_sec_q <= '0;
      cold_sec_q  <= '0;
      stage_adv_q <= 1'b0;
      cold_q      <= 1'b0;
      hatched_q   <= 1'b0;
      dead_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      stage_sec_q <= stage_sec_d;
      cold_sec_q  <= cold_sec_d;
      stage_adv_q <= stage_adv_d;
      cold_q      <= (state_d == StCold);
      hatched_q   <= (state_d == StHatched);
      dead_q      <= (state_d == StDead);
      busy_q      <= (state_d == StIncubate) || (state_d == StCold);
    end
  end

  assign bus.num       = num_q;
  assign bus.stage_adv = stage_adv_q;
  assign bus.cold      = cold_q;
  assign bus.hatched   = hatched_q;
  assign bus.dead      = dead_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_hatch_stage_ctrl.sv
// Directed bench for hatch_stage_ctrl with CLK_HZ=4: one stage per 8 cycles.
// Edge numbers below count posedges from the edge that samples start (edge 0).
module tb_hatch_stage_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   adv_cnt;

  hatch_stage_ctrl_if bus_if ();

  hatch_stage_ctrl #(
    .CLK_HZ     (4),
    .STAGE_SEC  (2),
    .NUM_STAGES (12),
    .COLD_LIMIT (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one posedge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus_if.stage_adv) adv_cnt++;
  endtask

  // Start pulse sampled on the next edge (edge 0); returns just after it.
  task automatic do_start();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  // Flags packed as {stage_adv, cold, hatched, dead, busy}.
  function automatic logic [4:0] flags();
    return {bus_if.stage_adv, bus_if.cold, bus_if.hatched, bus_if.dead, bus_if.busy};
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    adv_cnt  = 0;
    rst_n    = 1'b0;
    bus_if.start = 1'b0;
    bus_if.temp  = 1'b1;

    // 1. Reset, then idle without start.
    repeat (3) @(posedge clk);
    #1;
    check("rst_num", 32'(bus_if.num), 0);
    check("rst_flags", 32'(flags()), 0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("idle_num", 32'(bus_if.num), 0);
    check("idle_flags", 32'(flags()), 0);
    check("idle_adv_cnt", adv_cnt, 0);

    // 2./5a. Normal hatch, with an ignored start at edge 40.
    do_start();
    check("start_num", 32'(bus_if.num), 0);
    check("start_busy", 32'(bus_if.busy), 1);
    for (int e = 1; e <= 88; e++) begin
      bus_if.start = (e == 40);
      tick();
      check("run_adv", 32'(bus_if.stage_adv), (e % 8 == 0) ? 1 : 0);
      check("run_num", 32'(bus_if.num), 32'(e / 8));
    end
    bus_if.start = 1'b0;
    check("hatch_flag", 32'(bus_if.hatched), 1);
    check("hatch_busy", 32'(bus_if.busy), 0);
    adv_cnt = 0;
    repeat (50) tick();
    check("hatch_hold_num", 32'(bus_if.num), 11);
    check("hatch_hold_adv", adv_cnt, 0);

    // 5b. Restart after hatch.
    do_start();
    check("restart_num", 32'(bus_if.num), 0);
    check("restart_flags", 32'(flags()), 5'b00001);
    repeat (7) tick();
    check("restart_num7", 32'(bus_if.num), 0);
    tick();
    check("restart_num8", 32'(bus_if.num), 1);
    check("restart_adv8", 32'(bus_if.stage_adv), 1);

    // 3. Brief cold on edges 18..22; only the tick at edge 20 is lost.
    pulse_reset();
    check("r3_num", 32'(bus_if.num), 0);
    do_start();
    for (int e = 1; e <= 92; e++) begin
      bus_if.temp = !(e >= 18 && e <= 22);
      tick();
      if (e == 17) check("c_pre_cold", 32'(bus_if.cold), 0);
      if (e == 18) check("c_cold_on", 32'(flags()), 5'b01001);
      if (e == 22) check("c_cold_num", 32'(bus_if.num), 2);
      if (e == 23) check("c_cold_off", 32'(flags()), 5'b00001);
      if (e == 24) check("c_num24", 32'(bus_if.num), 2);
      if (e == 28) check("c_num28", 32'(bus_if.num), 3);
      if (e == 88) check("c_num88", 32'(bus_if.num), 10);
      if (e == 88) check("c_nohatch88", 32'(bus_if.hatched), 0);
    end
    check("c_hatch92", 32'(bus_if.hatched), 1);
    check("c_num92", 32'(bus_if.num), 11);
    bus_if.temp = 1'b1;

    // 4. Death after three cold ticks, then restart at edge 30.
    pulse_reset();
    do_start();
    for (int e = 1; e <= 29; e++) begin
      bus_if.temp = (e < 9);
      tick();
      if (e == 8) begin
        check("d_num8", 32'(bus_if.num), 1);
        adv_cnt = 0;
      end
      if (e == 9)  check("d_cold9", 32'(bus_if.cold), 1);
      if (e == 19) check("d_alive19", 32'(bus_if.dead), 0);
      if (e == 20) check("d_dead20", 32'(flags()), 5'b00010);
    end
    check("d_num_frozen", 32'(bus_if.num), 1);
    check("d_adv_silent", adv_cnt, 0);
    bus_if.temp = 1'b1;
    do_start();
    check("d_restart_num", 32'(bus_if.num), 0);
    check("d_restart_flags", 32'(flags()), 5'b00001);

    // 6. Asynchronous reset mid-run at num=6.
    pulse_reset();
    do_start();
    repeat (50) tick();
    check("a_num6", 32'(bus_if.num), 6);
    #2 rst_n = 1'b0;
    #1;
    check("a_async_num", 32'(bus_if.num), 0);
    check("a_async_busy", 32'(bus_if.busy), 0);
    #1 rst_n = 1'b1;
    adv_cnt = 0;
    repeat (20) tick();
    check("a_idle_num", 32'(bus_if.num), 0);
    check("a_idle_flags", 32'(flags()), 0);
    check("a_idle_adv", adv_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
